// File: rtl/exe_stage.sv
// exe_stage: EXE pipeline stage holding one instruction between ID and MEM, with ALU, optional multiplier (EXE_MUL_EN) and bypass outputs.
module exe_stage #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [31:0] in_pc,
  input  logic [11:0] in_alu_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [1:0]  in_mul_op,
  input  logic [4:0]  in_dest,
  input  logic        in_gr_we,
  input  logic        in_mem_we,
  input  logic        in_res_from_mem,
  input  logic [31:0] in_st_data,
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_result,
  output logic [4:0]  es_dest,
  output logic        es_gr_we,
  output logic        es_mem_we,
  output logic        es_res_from_mem,
  output logic [31:0] es_st_data,
  output logic        es_fwd_valid,
  output logic        es_fwd_is_load
);
  logic        es_valid;
  logic        es_ready_go;
  logic        accept;
  logic [11:0] alu_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_result;
  logic [31:0] sra_res;
  assign accept = ds_to_es_valid & es_allowin;
  assign es_allowin = ~es_valid | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid & es_ready_go & ~flush;
  assign es_fwd_valid = es_valid & es_gr_we & (es_dest != 5'd0);
  assign es_fwd_is_load = es_fwd_valid & es_res_from_mem;
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid        <= 1'b0;
      es_pc           <= '0;
      alu_op          <= '0;
      src1            <= '0;
      src2            <= '0;
      es_dest         <= '0;
      es_gr_we        <= 1'b0;
      es_mem_we       <= 1'b0;
      es_res_from_mem <= 1'b0;
      es_st_data      <= '0;
    end else begin
      if (flush)
        es_valid <= 1'b0;
      else if (es_allowin)
        es_valid <= ds_to_es_valid;
      if (accept) begin
        es_pc           <= in_pc;
        alu_op          <= in_alu_op;
        src1            <= in_src1;
        src2            <= in_src2;
        es_dest         <= in_dest;
        es_gr_we        <= in_gr_we;
        es_mem_we       <= in_mem_we;
        es_res_from_mem <= in_res_from_mem;
        es_st_data      <= in_st_data;
      end
    end
  end
  // sra kept as its own signal so the arithmetic shift stays in signed context
  assign sra_res = $signed(src1) >>> src2[4:0];
  always_comb begin
    alu_result = alu_op[11] ? src1 + src2 :
                 alu_op[10] ? src1 - src2 :
                 alu_op[9]  ? {31'b0, $signed(src1) < $signed(src2)} :
                 alu_op[8]  ? {31'b0, src1 < src2} :
                 alu_op[7]  ? src1 & src2 :
                 alu_op[6]  ? ~(src1 | src2) :
                 alu_op[5]  ? src1 | src2 :
                 alu_op[4]  ? src1 ^ src2 :
                 alu_op[3]  ? src1 << src2[4:0] :
                 alu_op[2]  ? src1 >> src2[4:0] :
                 alu_op[1]  ? sra_res :
                 alu_op[0]  ? src2 : 32'b0;
  end
`ifdef EXE_MUL_EN
  localparam logic [1:0] LAST = 2'(MUL_LAT - 1);
  logic [1:0]  mul_op;
  logic [1:0]  cnt;
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [31:0] mul_res;
  always_ff @(posedge clk) begin
    if (reset)
      mul_op <= '0;
    else if (accept)
      mul_op <= in_mul_op;
  end
  // counter restarts whenever the stage can take a new instruction
  always_ff @(posedge clk) begin
    if (reset | flush | es_allowin)
      cnt <= '0;
    else if (es_valid & (mul_op != 2'b00) & (cnt != LAST))
      cnt <= cnt + 2'd1;
  end
  assign es_ready_go = ~(es_valid & (mul_op != 2'b00) & (cnt != LAST));
  assign prod_u = {32'b0, src1} * {32'b0, src2};
  assign prod_s = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
  assign mul_res = (mul_op == 2'b01) ? prod_u[31:0] :
                   (mul_op == 2'b10) ? prod_s[63:32] : prod_u[63:32];
  assign es_result = (mul_op != 2'b00) ? mul_res : alu_result;
`else
  logic unused_mul;
  assign unused_mul = ^in_mul_op ^ (MUL_LAT == 0);
  assign es_ready_go = 1'b1;
  assign es_result = alu_result;
`endif
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed and randomized checks of exe_stage against a transaction-level model (honours EXE_MUL_EN).
module tb_exe_stage;
  localparam int MUL_LAT = 2;
`ifdef EXE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mul;
    logic [4:0]  dest;
    logic        gr_we;
    logic        mem_we;
    logic        ld;
    logic [31:0] st;
  } instr_t;
  localparam logic [11:0] OP_ADD = 12'h800, OP_SLTU = 12'h100, OP_SRA = 12'h002;
  logic clk = 1'b0;
  logic reset, flush, ds_to_es_valid, ms_allowin;
  instr_t drv;
  logic es_allowin, es_to_ms_valid, es_gr_we, es_mem_we, es_res_from_mem, es_fwd_valid, es_fwd_is_load;
  logic [31:0] es_pc, es_result, es_st_data;
  logic [4:0] es_dest;
  int total = 0, bad = 0;
  instr_t m_i;
  bit m_valid = 0;
  int m_age = 0;
  always #5 clk = ~clk;
  exe_stage #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .in_pc(drv.pc), .in_alu_op(drv.op), .in_src1(drv.a), .in_src2(drv.b), .in_mul_op(drv.mul),
    .in_dest(drv.dest), .in_gr_we(drv.gr_we), .in_mem_we(drv.mem_we), .in_res_from_mem(drv.ld),
    .in_st_data(drv.st), .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc),
    .es_result(es_result), .es_dest(es_dest), .es_gr_we(es_gr_we), .es_mem_we(es_mem_we),
    .es_res_from_mem(es_res_from_mem), .es_st_data(es_st_data), .es_fwd_valid(es_fwd_valid),
    .es_fwd_is_load(es_fwd_is_load)
  );
  function automatic logic [31:0] ref_result(instr_t t);
    longint signed ps;
    longint unsigned pu;
    int s;
    s = int'(t.b[4:0]);
    if (MUL_EN && t.mul != 2'b00) begin
      ps = longint'($signed(t.a)) * longint'($signed(t.b));
      pu = longint'({32'b0, t.a}) * longint'({32'b0, t.b});
      return (t.mul == 2'b01) ? pu[31:0] : (t.mul == 2'b10) ? ps[63:32] : pu[63:32];
    end
    if (t.op[11]) return t.a + t.b;
    if (t.op[10]) return t.a - t.b;
    if (t.op[9])  return ($signed(t.a) < $signed(t.b)) ? 32'd1 : 32'd0;
    if (t.op[8])  return (t.a < t.b) ? 32'd1 : 32'd0;
    if (t.op[7])  return t.a & t.b;
    if (t.op[6])  return ~(t.a | t.b);
    if (t.op[5])  return t.a | t.b;
    if (t.op[4])  return t.a ^ t.b;
    if (t.op[3])  return t.a << s;
    if (t.op[2])  return t.a >> s;
    if (t.op[1])  return (t.a >> s) | (t.a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
    if (t.op[0])  return t.b;
    return 32'h0;
  endfunction
  function automatic int lat(instr_t t);
    return (MUL_EN && t.mul != 2'b00) ? MUL_LAT : 1;
  endfunction
  function automatic bit m_ready();
    return m_valid && (m_age >= lat(m_i) - 1);
  endfunction
  task automatic model_clock();
    bit allow;
    allow = !m_valid || (m_ready() && ms_allowin);
    if (reset || flush) m_valid = 0;
    else if (allow) begin
      m_valid = ds_to_es_valid;
      if (ds_to_es_valid) begin
        m_i = drv;
        m_age = 0;
      end
    end else m_age++;
  endtask
  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask
  task automatic put(logic [11:0] op, logic [31:0] a, logic [31:0] b, logic [1:0] mul);
    drv = '0;
    drv.pc = $urandom;
    drv.op = op;
    drv.a = a;
    drv.b = b;
    drv.mul = mul;
  endtask
  task automatic test_reset();
    reset = 1; flush = 0; ds_to_es_valid = 0; ms_allowin = 0; drv = '0;
    tick(); tick();
    reset = 0;
    @(negedge clk);
    total += 5;
    if (es_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b want=1", es_allowin); end
    if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL reset_to_ms got=%b want=0", es_to_ms_valid); end
    if (es_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", es_result); end
    if (es_fwd_valid !== 1'b0) begin bad++; $display("FAIL reset_fwd got=%b want=0", es_fwd_valid); end
    if (es_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", es_pc); end
    tick();
  endtask
  task automatic test_alu();
    logic [11:0] ops [3] = '{OP_ADD, OP_SLTU, 12'h000};
    logic [31:0] as  [3] = '{32'h7FFF_FFFF, 32'h1, 32'h1234_5678};
    logic [31:0] bs  [3] = '{32'h1, 32'hFFFF_FFFF, 32'h9};
    logic [31:0] exp [3] = '{32'h8000_0000, 32'h1, 32'h0};
    ms_allowin = 1;
    for (int i = 0; i < 3; i++) begin
      put(ops[i], as[i], bs[i], 2'b00);
      ds_to_es_valid = 1;
      tick();
      ds_to_es_valid = 0;
      @(negedge clk);
      total += 2;
      if (es_to_ms_valid !== 1'b1) begin bad++; $display("FAIL alu%0d_valid got=%b want=1", i, es_to_ms_valid); end
      if (es_result !== exp[i]) begin bad++; $display("FAIL alu%0d_result got=%h want=%h", i, es_result, exp[i]); end
      tick();
    end
  endtask
  task automatic test_backpressure();
    ms_allowin = 0;
    put(OP_SRA, 32'h8000_0000, 32'd31, 2'b00);
    ds_to_es_valid = 1;
    tick();
    ds_to_es_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total += 3;
      if (es_allowin !== 1'b0) begin bad++; $display("FAIL bp%0d_allowin got=%b want=0", i, es_allowin); end
      if (es_to_ms_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_valid got=%b want=1", i, es_to_ms_valid); end
      if (es_result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL bp%0d_result got=%h want=ffffffff", i, es_result); end
      tick();
    end
    ms_allowin = 1;
    @(negedge clk);
    total += 2;
    if (es_allowin !== 1'b1) begin bad++; $display("FAIL bp_release_allowin got=%b want=1", es_allowin); end
    if (es_result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL bp_release_result got=%h want=ffffffff", es_result); end
    tick();
    @(negedge clk);
    total++;
    if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL bp_once got=%b want=0", es_to_ms_valid); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] a, b;
    ms_allowin = 1;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      put(OP_ADD, a, b, 2'b00);
      ds_to_es_valid = 1;
      tick();
      @(negedge clk);
      total += 2;
      if (es_to_ms_valid !== 1'b1) begin bad++; $display("FAIL b2b%0d_valid got=%b want=1", i, es_to_ms_valid); end
      if (es_result !== a + b) begin bad++; $display("FAIL b2b%0d_result got=%h want=%h", i, es_result, a + b); end
    end
    ds_to_es_valid = 0;
    tick();
  endtask
  task automatic test_mul();
    ms_allowin = 1;
`ifdef EXE_MUL_EN
    for (int i = 0; i < 2; i++) begin
      put(OP_ADD, 32'hFFFF_FFFF, 32'h2, (i == 0) ? 2'b10 : 2'b01);
      ds_to_es_valid = 1;
      tick();
      ds_to_es_valid = 0;
      @(negedge clk);
      total += 2;
      if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL mul%0d_busy got=%b want=0", i, es_to_ms_valid); end
      if (es_allowin !== 1'b0) begin bad++; $display("FAIL mul%0d_allowin got=%b want=0", i, es_allowin); end
      tick();
      @(negedge clk);
      total += 2;
      if (es_to_ms_valid !== 1'b1) begin bad++; $display("FAIL mul%0d_done got=%b want=1", i, es_to_ms_valid); end
      if (es_result !== ((i == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE))
        begin bad++; $display("FAIL mul%0d_result got=%h want=%h", i, es_result, (i == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE); end
      tick();
    end
`else
    put(OP_ADD, 32'hFFFF_FFFF, 32'h2, 2'b10);
    ds_to_es_valid = 1;
    tick();
    ds_to_es_valid = 0;
    @(negedge clk);
    total += 2;
    if (es_to_ms_valid !== 1'b1) begin bad++; $display("FAIL nomul_valid got=%b want=1", es_to_ms_valid); end
    if (es_result !== 32'h1) begin bad++; $display("FAIL nomul_result got=%h want=1", es_result); end
    tick();
`endif
  endtask
  task automatic test_flush();
    ms_allowin = 0;
    put(OP_ADD, 32'h5, 32'h6, 2'b00);
    ds_to_es_valid = 1;
    tick();
    put(OP_ADD, 32'h7, 32'h8, 2'b00);
    flush = 1;
    @(negedge clk);
    total++;
    if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL flush_gate got=%b want=0", es_to_ms_valid); end
    tick();
    flush = 0; ds_to_es_valid = 0; ms_allowin = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total += 2;
      if (es_to_ms_valid !== 1'b0) begin bad++; $display("FAIL flush%0d_valid got=%b want=0", i, es_to_ms_valid); end
      if (es_allowin !== 1'b1) begin bad++; $display("FAIL flush%0d_allowin got=%b want=1", i, es_allowin); end
      tick();
    end
  endtask
  task automatic test_fwd();
    logic [4:0] d [3] = '{5'd5, 5'd0, 5'd7};
    logic       l [3] = '{1'b1, 1'b0, 1'b0};
    logic       v [3] = '{1'b1, 1'b0, 1'b1};
    ms_allowin = 1;
    for (int i = 0; i < 3; i++) begin
      put(OP_ADD, 32'h100, 32'h4, 2'b00);
      drv.dest = d[i]; drv.gr_we = 1; drv.ld = l[i];
      ds_to_es_valid = 1;
      tick();
      @(negedge clk);
      total += 2;
      if (es_fwd_valid !== v[i]) begin bad++; $display("FAIL fwd%0d_valid got=%b want=%b", i, es_fwd_valid, v[i]); end
      if (es_fwd_is_load !== (v[i] & l[i])) begin bad++; $display("FAIL fwd%0d_load got=%b want=%b", i, es_fwd_is_load, v[i] & l[i]); end
    end
    ds_to_es_valid = 0;
    tick();
  endtask
  task automatic test_random();
    bit exp_allow, exp_tms, exp_fv, exp_fl;
    logic [31:0] exp_res;
    for (int n = 0; n < 400; n++) begin
      drv.pc = $urandom;
      drv.op = ($urandom_range(0, 15) == 0) ? 12'h000 : 12'(1 << $urandom_range(0, 11));
      drv.a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      drv.b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      drv.mul = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      drv.dest = 5'($urandom_range(0, 31));
      drv.gr_we = 1'($urandom_range(0, 1));
      drv.mem_we = 1'($urandom_range(0, 1));
      drv.ld = 1'($urandom_range(0, 1));
      drv.st = $urandom;
      ds_to_es_valid = $urandom_range(0, 3) != 0;
      ms_allowin = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      @(negedge clk);
      exp_allow = !m_valid || (m_ready() && ms_allowin);
      exp_tms = m_ready() && !flush;
      exp_fv = m_valid && m_i.gr_we && (m_i.dest != 5'd0);
      exp_fl = exp_fv && m_i.ld;
      total += 4;
      if (es_allowin !== exp_allow) begin bad++; $display("FAIL rnd%0d_allowin got=%b want=%b", n, es_allowin, exp_allow); end
      if (es_to_ms_valid !== exp_tms) begin bad++; $display("FAIL rnd%0d_to_ms got=%b want=%b", n, es_to_ms_valid, exp_tms); end
      if (es_fwd_valid !== exp_fv) begin bad++; $display("FAIL rnd%0d_fwd got=%b want=%b", n, es_fwd_valid, exp_fv); end
      if (es_fwd_is_load !== exp_fl) begin bad++; $display("FAIL rnd%0d_fwd_load got=%b want=%b", n, es_fwd_is_load, exp_fl); end
      if (m_ready()) begin
        exp_res = ref_result(m_i);
        total += 4;
        if (es_result !== exp_res) begin bad++; $display("FAIL rnd%0d_result got=%h want=%h", n, es_result, exp_res); end
        if (es_pc !== m_i.pc) begin bad++; $display("FAIL rnd%0d_pc got=%h want=%h", n, es_pc, m_i.pc); end
        if ({es_dest, es_gr_we, es_mem_we, es_res_from_mem} !== {m_i.dest, m_i.gr_we, m_i.mem_we, m_i.ld})
          begin bad++; $display("FAIL rnd%0d_ctrl got=%h want=%h", n, {es_dest, es_gr_we, es_mem_we, es_res_from_mem}, {m_i.dest, m_i.gr_we, m_i.mem_we, m_i.ld}); end
        if (es_st_data !== m_i.st) begin bad++; $display("FAIL rnd%0d_st got=%h want=%h", n, es_st_data, m_i.st); end
      end
      tick();
    end
    flush = 0;
  endtask
  initial begin
    test_reset();
    test_alu();
    test_backpressure();
    test_back_to_back();
    test_mul();
    test_flush();
    test_fwd();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
